// File: rtl/irq_ctrl_if.sv
// CPU-side register bus of irq_ctrl: address/data/strobe from the CPU, registered read data back.
interface irq_ctrl_if;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        rw;
  logic        bus_en;
  logic [7:0]  rdata;
  logic        rsel;

  modport master (
    output addr, wdata, rw, bus_en,
    input  rdata, rsel
  );

  modport slave (
    input  addr, wdata, rw, bus_en,
    output rdata, rsel
  );
endinterface

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller driving cpu6502 irq/nmi: edge/level sources, mask, vector, NMI stretch.
// Optional IRQ_CTRL_SYNC_EN adds 2-flop synchronizers on src and nmi_in.
module irq_ctrl #(
  parameter int          NSRC      = 8,
  parameter logic [15:0] BASE_ADDR = 16'hFF00,
  parameter int          NMI_HOLD  = 4
) (
  input  logic            clk,
  input  logic            reset,
  irq_ctrl_if.slave       bus,
  input  logic [NSRC-1:0] src,
  input  logic            nmi_in,
  output logic            irq,
  output logic            nmi
);

  localparam logic [7:0] SRC_MASK = (NSRC >= 8) ? 8'hFF : 8'((16'd1 << NSRC) - 16'd1);
  localparam logic [3:0] HOLD_VAL = 4'(NMI_HOLD);

  localparam logic [2:0] OFF_STATUS = 3'd0;
  localparam logic [2:0] OFF_MASK   = 3'd1;
  localparam logic [2:0] OFF_MODE   = 3'd2;
  localparam logic [2:0] OFF_VECTOR = 3'd3;

  function automatic logic [2:0] lowest_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  logic [7:0] src_in_s;
  logic       nmi_in_s;

  logic [7:0] src_q_r;
  logic       nmi_q_r;
  logic [7:0] pend_r;
  logic [7:0] mask_r;
  logic [7:0] mode_r;
  logic [3:0] nmi_cnt_r;
  logic       nmi_r;
  logic       irq_r;
  logic [7:0] rdata_r;
  logic       rsel_r;

  logic       hit_s;
  logic       wr_s;
  logic       rd_s;
  logic [2:0] off_s;
  logic [7:0] pending_s;
  logic [7:0] active_s;
  logic [7:0] clr_s;
  logic [7:0] src_edge_s;
  logic [7:0] pend_nxt_s;
  logic [7:0] vector_s;
  logic [7:0] rd_mux_s;
  logic       nmi_edge_s;

`ifdef IRQ_CTRL_SYNC_EN
  logic [7:0] src_meta_r;
  logic [7:0] src_sync_r;
  logic       nmi_meta_r;
  logic       nmi_sync_r;

  // Two-flop synchronizers; the nmi path resets high so a held request does not fire.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_meta_r <= 8'h00;
      src_sync_r <= 8'h00;
      nmi_meta_r <= 1'b1;
      nmi_sync_r <= 1'b1;
    end else begin
      src_meta_r <= 8'(src);
      src_sync_r <= src_meta_r;
      nmi_meta_r <= nmi_in;
      nmi_sync_r <= nmi_meta_r;
    end
  end

  assign src_in_s = src_sync_r & SRC_MASK;
  assign nmi_in_s = nmi_sync_r;
`else
  assign src_in_s = 8'(src) & SRC_MASK;
  assign nmi_in_s = nmi_in;
`endif

  // Bus decode, pending view, edge detect and read mux.
  always_comb begin
    hit_s      = bus.bus_en && (bus.addr[15:3] == BASE_ADDR[15:3]);
    wr_s       = hit_s && !bus.rw;
    rd_s       = hit_s && bus.rw;
    off_s      = bus.addr[2:0];
    // Level bits mirror src_q directly, so leaving edge mode drops any latched state at once.
    pending_s  = ((mode_r & pend_r) | (~mode_r & src_q_r)) & SRC_MASK;
    active_s   = pending_s & mask_r;
    src_edge_s = src_in_s & ~src_q_r;
    nmi_edge_s = nmi_in_s & ~nmi_q_r;
    if (wr_s && (off_s == OFF_STATUS)) begin
      clr_s = bus.wdata & SRC_MASK;
    end else begin
      clr_s = 8'h00;
    end
    pend_nxt_s = mode_r & SRC_MASK & (src_edge_s | (pend_r & ~clr_s));
    vector_s   = {|active_s, 4'b0000, lowest_idx(active_s)};
    case (off_s)
      OFF_STATUS: rd_mux_s = pending_s;
      OFF_MASK:   rd_mux_s = mask_r;
      OFF_MODE:   rd_mux_s = mode_r;
      OFF_VECTOR: rd_mux_s = vector_s;
      default:    rd_mux_s = 8'h00;
    endcase
  end

  // Input history, latched edge state and irq output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_q_r <= 8'h00;
      pend_r  <= 8'h00;
      irq_r   <= 1'b0;
    end else begin
      src_q_r <= src_in_s;
      pend_r  <= pend_nxt_s;
      irq_r   <= |active_s;
    end
  end

  // Software-writable MASK and MODE registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_r <= 8'h00;
      mode_r <= 8'h00;
    end else if (wr_s) begin
      case (off_s)
        OFF_MASK: mask_r <= bus.wdata & SRC_MASK;
        OFF_MODE: mode_r <= bus.wdata & SRC_MASK;
        default: begin
          mask_r <= mask_r;
          mode_r <= mode_r;
        end
      endcase
    end else begin
      mask_r <= mask_r;
      mode_r <= mode_r;
    end
  end

  // Registered read port; rdata holds between accesses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_r <= 8'h00;
      rsel_r  <= 1'b0;
    end else if (rd_s) begin
      rdata_r <= rd_mux_s;
      rsel_r  <= 1'b1;
    end else begin
      rdata_r <= rdata_r;
      rsel_r  <= 1'b0;
    end
  end

  // NMI stretcher: each rising edge (re)loads the hold counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nmi_q_r   <= 1'b1;
      nmi_cnt_r <= 4'd0;
      nmi_r     <= 1'b0;
    end else begin
      nmi_q_r <= nmi_in_s;
      if (nmi_edge_s) begin
        nmi_cnt_r <= HOLD_VAL;
      end else if (nmi_cnt_r != 4'd0) begin
        nmi_cnt_r <= nmi_cnt_r - 4'd1;
      end else begin
        nmi_cnt_r <= nmi_cnt_r;
      end
      // Registered copy of (next counter != 0).
      nmi_r <= nmi_edge_s | (nmi_cnt_r > 4'd1);
    end
  end

  assign irq       = irq_r;
  assign nmi       = nmi_r;
  assign bus.rdata = rdata_r;
  assign bus.rsel  = rsel_r;

endmodule
